serial_adder_fsm: RTL and testbench



---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fa_using_1x8demux.sv | 21 ++
 rtl/serial_adder_fsm.sv | 123 ++++++++++++
 tb/tb_serial_adder_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and sizing helper for the bit-serial adder sequencer.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit counter width; never below one bit so WIDTH=2 still gets a counter.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fa_using_1x8demux.sv
// 1-bit full adder built from a 1-to-8 demux addressed by {a,b,cin}.
module fa_using_1x8demux (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic [7:0] w_d;

   always_comb begin
      w_d = '0;
      w_d[{i_a, i_b, i_cin}] = 1'b1;
   end

   // Minterms with an odd count of ones give sum; two or more ones give carry.
   assign o_sum  = w_d[1] | w_d[2] | w_d[4] | w_d[7];
   assign o_cout = w_d[3] | w_d[5] | w_d[6] | w_d[7];

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: feeds one full-adder cell LSB first, one bit per clock.
module serial_adder_fsm
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned       CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_wsum;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             w_s;
   logic             w_co;

   fa_using_1x8demux u_fa (
      .i_a    (r_opa[0]),
      .i_b    (r_opb[0]),
      .i_cin  (r_carry),
      .o_sum  (w_s),
      .o_cout (w_co)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == LAST) begin
               w_last = 1'b1;
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_SHIFT;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up exactly with SHIFT/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next == ST_SHIFT);
         r_done <= (w_next == ST_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_wsum  <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_opa   <= a;
         r_opb   <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == ST_SHIFT) begin
         r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
         r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
         r_wsum  <= {w_s, r_wsum[WIDTH-1:1]};
         r_carry <= w_co;
         r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
         if (w_last) begin
            r_sum  <= {w_s, r_wsum[WIDTH-1:1]};
            r_cout <= w_co;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench: drivers push a+b+cin expectations, monitors pop on each done pulse.
module tb_serial_adder_fsm;

   typedef struct {
      logic [32:0] exp;
      longint      due;
   } item_t;

   logic       clk = 1'b0;
   longint     cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic       rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       rst4 = 1'b1, start4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   item_t       sb8[$];
   item_t       sb4[$];
   logic [32:0] hold8 = '0;
   logic [32:0] hold4 = '0;
   int          run8 = 0;
   int          run4 = 0;

   serial_adder_fsm #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_fsm #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitors: result/latency on done, busy run length, sum/cout held steady while busy.
   always @(negedge clk) begin
      item_t it;
      if (busy8 === 1'b1) begin
         run8++;
         chk("sum8_stable", 64'(sum8), 64'(hold8[7:0]));
         chk("cout8_stable", 64'(cout8), 64'(hold8[8]));
      end else begin
         if (done8 === 1'b1) begin
            chk("busy8_len", 64'(run8), 64'd8);
            if (sb8.size() == 0) begin
               checks++; errors++;
               $display("FAIL done8_unexpected: got done pulse expected none (cycle %0d)", cyc);
            end else begin
               it = sb8.pop_front();
               chk("sum8", 64'(sum8), 64'(it.exp[7:0]));
               chk("cout8", 64'(cout8), 64'(it.exp[8]));
               chk("lat8", 64'(cyc), 64'(it.due));
               hold8 = it.exp;
            end
         end
         run8 = 0;
      end
   end

   always @(negedge clk) begin
      item_t it;
      if (busy4 === 1'b1) begin
         run4++;
         chk("sum4_stable", 64'(sum4), 64'(hold4[3:0]));
      end else begin
         if (done4 === 1'b1) begin
            chk("busy4_len", 64'(run4), 64'd4);
            if (sb4.size() == 0) begin
               checks++; errors++;
               $display("FAIL done4_unexpected: got done pulse expected none (cycle %0d)", cyc);
            end else begin
               it = sb4.pop_front();
               chk("sum4_cout4", 64'({cout4, sum4}), 64'(it.exp[4:0]));
               chk("lat4", 64'(cyc), 64'(it.due));
               hold4 = it.exp;
            end
         end
         run4 = 0;
      end
   end

   // Called at a negedge; the following posedge is the accepting edge.
   task automatic drive8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      item_t it;
      start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
      it.exp = 33'(av) + 33'(bv) + 33'(cv);
      it.due = cyc + 1 + 8;
      sb8.push_back(it);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   task automatic drive4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
      item_t it;
      start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
      it.exp = 33'(av) + 33'(bv) + 33'(cv);
      it.due = cyc + 1 + 4;
      sb4.push_back(it);
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
   endtask

   task automatic wait_done8();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done8 !== 1'b1 && n < 40);
      if (done8 !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done8_timeout: got no done within 40 cycles expected done");
      end
   endtask

   task automatic wait_done4();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done4 !== 1'b1 && n < 30);
      if (done4 !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done4_timeout: got no done within 30 cycles expected done");
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_done8", 64'(done8), 64'd0);
      chk("rst_sum8", 64'({cout8, sum8}), 64'd0);
      chk("rst_state4", 64'({busy4, done4, cout4, sum4}), 64'd0);
      rst8 = 1'b0; rst4 = 1'b0;

      @(negedge clk); drive8(8'h5A, 8'h3C, 1'b0); wait_done8();
      @(negedge clk); drive8(8'hFF, 8'h01, 1'b0); wait_done8();
      @(negedge clk); drive8(8'hFF, 8'hFF, 1'b1); wait_done8();

      // Start during SHIFT must be ignored.
      @(negedge clk); drive8(8'h0F, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8();
      repeat (12) begin
         @(negedge clk);
         chk("no_extra_done8", 64'(done8), 64'd0);
      end

      // Back-to-back: start held through the DONE cycle.
      @(negedge clk); drive8(8'h20, 8'h30, 1'b0); wait_done8();
      drive8(8'h03, 8'h04, 1'b0); wait_done8();

      // Reset on the 4th SHIFT edge aborts the operation.
      @(negedge clk); drive8(8'h55, 8'h66, 1'b1);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      sb8.delete();
      @(posedge clk); #1 hold8 = '0;
      @(negedge clk);
      chk("abort_busy8", 64'(busy8), 64'd0);
      chk("abort_done8", 64'(done8), 64'd0);
      chk("abort_sum8", 64'(sum8), 64'd0);
      chk("abort_cout8", 64'(cout8), 64'd0);
      rst8 = 1'b0;
      repeat (15) begin
         @(negedge clk);
         chk("no_done_after_abort", 64'(done8), 64'd0);
      end
      @(negedge clk); drive8(8'h81, 8'h7F, 1'b1); wait_done8();

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         drive8(8'($urandom), 8'($urandom), 1'($urandom));
         wait_done8();
      end

      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         @(negedge clk);
         drive4(v[7:4], v[3:0], v[8]);
         wait_done4();
      end

      repeat (10) @(negedge clk);
      chk("sb8_drained", 64'(sb8.size()), 64'd0);
      chk("sb4_drained", 64'(sb4.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
